// File: rtl/wdt_core_if.sv
// Key/configuration/status bundle for the watchdog core.
// The master side drives keys and configuration writes, and the slave side (the core) returns status.
interface wdt_core_if;
  logic        key_wr;
  logic [15:0] key_data;
  logic        pr_wr;
  logic [2:0]  pr_data;
  logic        rlr_wr;
  logic [11:0] rlr_data;
  logic        wdt_reset;
  logic        running;
  logic        locked;
  logic [11:0] count;
  logic        early_warn;

  modport master (
    output key_wr, key_data, pr_wr, pr_data, rlr_wr, rlr_data,
    input  wdt_reset, running, locked, count, early_warn
  );

  modport slave (
    input  key_wr, key_data, pr_wr, pr_data, rlr_wr, rlr_data,
    output wdt_reset, running, locked, count, early_warn
  );
endinterface

// File: rtl/wdt_core.sv
// Independent watchdog: a key-protected down-counter clocked by synchronized wdt_clk ticks.
// On timeout it issues a fixed-width reset pulse and then restarts from the reload value.
module wdt_core #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned EWI_THRESH = 64,
  parameter logic [15:0] KEY_START  = 16'hCCCC,
  parameter logic [15:0] KEY_RELOAD = 16'hAAAA,
  parameter logic [15:0] KEY_UNLOCK = 16'h5555
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wdt_clk,
  wdt_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  state_t      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] rlr_q, rlr_d;
  logic [2:0]  pr_q, pr_d;
  logic [2:0]  pr_act_q, pr_act_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  fire_q, fire_d;
  logic        locked_q, locked_d;
  logic        ew_q, ew_d;
  logic        s1_q, s2_q, s3_q;
  logic        tick;
  logic        load;

  function automatic logic [7:0] div_last(input logic [2:0] pr);
    logic [8:0] d;
    d = (pr == 3'd7) ? 9'd256 : (9'd4 << pr);
    return 8'(d - 9'd1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= wdt_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  // The divider in use is latched at load so PR writes only take effect at the next start/reload.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rlr_d    = rlr_q;
    pr_d     = pr_q;
    pr_act_d = pr_act_q;
    presc_d  = presc_q;
    fire_d   = fire_q;
    locked_d = locked_q;
    load     = 1'b0;

    if (!locked_q) begin
      if (bus.pr_wr)  pr_d  = bus.pr_data;
      if (bus.rlr_wr) rlr_d = bus.rlr_data;
    end

    case (state_q)
      FIRE: begin
        if (fire_q == 8'(RST_CYCLES - 1)) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          fire_d = fire_q + 8'd1;
        end
      end
      default: begin
        if (bus.key_wr) begin
          if (bus.key_data == KEY_UNLOCK) begin
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
            if (bus.key_data == KEY_START && state_q == IDLE) begin
              state_d = RUN;
              load    = 1'b1;
            end else if (bus.key_data == KEY_RELOAD && state_q == RUN) begin
              load = 1'b1;
            end
          end
        end
        // A reload in the same cycle as a prescaler wrap suppresses the decrement.
        if (state_q == RUN && !load && tick) begin
          if (presc_q == div_last(pr_act_q)) begin
            presc_d = 8'd0;
            if (count_q == 12'd0) begin
              state_d = FIRE;
              fire_d  = 8'd0;
            end else begin
              count_d = count_q - 12'd1;
            end
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
    endcase

    if (load) begin
      count_d  = rlr_q;
      presc_d  = 8'd0;
      pr_act_d = pr_q;
    end

    ew_d = (state_d == RUN) && (count_d <= 12'(EWI_THRESH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 12'hFFF;
      rlr_q    <= 12'hFFF;
      pr_q     <= 3'd0;
      pr_act_q <= 3'd0;
      presc_q  <= 8'd0;
      fire_q   <= 8'd0;
      locked_q <= 1'b1;
      ew_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rlr_q    <= rlr_d;
      pr_q     <= pr_d;
      pr_act_q <= pr_act_d;
      presc_q  <= presc_d;
      fire_q   <= fire_d;
      locked_q <= locked_d;
      ew_q     <= ew_d;
    end
  end

  assign bus.wdt_reset  = (state_q == FIRE);
  assign bus.running    = (state_q != IDLE);
  assign bus.locked     = locked_q;
  assign bus.count      = count_q;
  assign bus.early_warn = ew_q;

endmodule
